// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates one AXI4-Lite memory port between the IFU (M0, read
// only) and the LSU (M1, read+write). One transaction is in flight at a time;
// the grant is registered in IDLE, and channel payloads then pass
// combinationally between the granted master and the slave.
// Optional feature: define ARB_ROUND_ROBIN_EN to make the M0-vs-M1 choice
// round-robin instead of fixed priority M1 > M0.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  // M0: IFU read
  input  logic [ADDR_W-1:0]   m0_araddr,
  input  logic                m0_arvalid,
  output logic                m0_arready,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic [1:0]          m0_rresp,
  output logic                m0_rvalid,
  input  logic                m0_rready,
  // M1: LSU read
  input  logic [ADDR_W-1:0]   m1_araddr,
  input  logic                m1_arvalid,
  output logic                m1_arready,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic [1:0]          m1_rresp,
  output logic                m1_rvalid,
  input  logic                m1_rready,
  // M1: LSU write
  input  logic [ADDR_W-1:0]   m1_awaddr,
  input  logic                m1_awvalid,
  output logic                m1_awready,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  input  logic                m1_wvalid,
  output logic                m1_wready,
  output logic [1:0]          m1_bresp,
  output logic                m1_bvalid,
  input  logic                m1_bready,
  // Slave side
  output logic [ADDR_W-1:0]   s_araddr,
  output logic                s_arvalid,
  input  logic                s_arready,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic [1:0]          s_rresp,
  input  logic                s_rvalid,
  output logic                s_rready,
  output logic [ADDR_W-1:0]   s_awaddr,
  output logic                s_awvalid,
  input  logic                s_awready,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  output logic                s_wvalid,
  input  logic                s_wready,
  input  logic [1:0]          s_bresp,
  input  logic                s_bvalid,
  output logic                s_bready
);

  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WADDR, WRESP} state_t;

  state_t state, state_n;
  logic   gnt, gnt_n;          // 0 = M0, 1 = M1
  logic   aw_done, aw_done_n;
  logic   w_done, w_done_n;

  logic   m1_wr_req, m1_req, pick_m1;
  logic   r_done, b_done;

  assign m1_wr_req = m1_awvalid | m1_wvalid;
  assign m1_req    = m1_wr_req | m1_arvalid;
  assign r_done    = (state == RDATA) && s_rvalid && s_rready;
  assign b_done    = (state == WRESP) && s_bvalid && s_bready;

`ifdef ARB_ROUND_ROBIN_EN
  logic last;  // master of the most recently completed transaction

  // Remember who finished last so a contended IDLE favours the other master
  always_ff @(posedge clk) begin
    if (rst)         last <= 1'b0;
    else if (r_done) last <= gnt;
    else if (b_done) last <= 1'b1;
  end

  assign pick_m1 = m1_req && (!m0_arvalid || !last);
`else
  assign pick_m1 = m1_req;
`endif

  // State, grant and write-channel completion flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state   <= state_n;
      gnt     <= gnt_n;
      aw_done <= aw_done_n;
      w_done  <= w_done_n;
    end
  end

  // Next state: arbitrate in IDLE, advance on each channel handshake
  always_comb begin
    state_n   = state;
    gnt_n     = gnt;
    aw_done_n = aw_done;
    w_done_n  = w_done;
    case (state)
      IDLE: begin
        if (pick_m1) begin
          gnt_n   = 1'b1;
          // a write from M1 beats its own read
          state_n = m1_wr_req ? WADDR : RADDR;
        end else if (m0_arvalid) begin
          gnt_n   = 1'b0;
          state_n = RADDR;
        end
      end
      RADDR: if (s_arvalid && s_arready) state_n = RDATA;
      RDATA: if (r_done) state_n = IDLE;
      WADDR: begin
        // AW and W may complete in either order or together
        aw_done_n = aw_done | (s_awvalid & s_awready);
        w_done_n  = w_done  | (s_wvalid  & s_wready);
        if (aw_done_n && w_done_n) begin
          state_n   = WRESP;
          aw_done_n = 1'b0;
          w_done_n  = 1'b0;
        end
      end
      WRESP: if (b_done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Channel routing; everything is quiet in IDLE and while rst is held
  always_comb begin
    m0_arready = 1'b0;
    m0_rdata   = '0;
    m0_rresp   = '0;
    m0_rvalid  = 1'b0;
    m1_arready = 1'b0;
    m1_rdata   = '0;
    m1_rresp   = '0;
    m1_rvalid  = 1'b0;
    m1_awready = 1'b0;
    m1_wready  = 1'b0;
    m1_bresp   = '0;
    m1_bvalid  = 1'b0;
    s_araddr   = '0;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    s_awaddr   = '0;
    s_awvalid  = 1'b0;
    s_wdata    = '0;
    s_wstrb    = '0;
    s_wvalid   = 1'b0;
    s_bready   = 1'b0;
    if (!rst) begin
      case (state)
        RADDR: begin
          if (gnt) begin
            s_araddr   = m1_araddr;
            s_arvalid  = m1_arvalid;
            m1_arready = s_arready;
          end else begin
            s_araddr   = m0_araddr;
            s_arvalid  = m0_arvalid;
            m0_arready = s_arready;
          end
        end
        RDATA: begin
          if (gnt) begin
            m1_rdata  = s_rdata;
            m1_rresp  = s_rresp;
            m1_rvalid = s_rvalid;
            s_rready  = m1_rready;
          end else begin
            m0_rdata  = s_rdata;
            m0_rresp  = s_rresp;
            m0_rvalid = s_rvalid;
            s_rready  = m0_rready;
          end
        end
        WADDR: begin
          // a channel that already handshook is masked so it is not repeated
          s_awaddr   = m1_awaddr;
          s_awvalid  = m1_awvalid & ~aw_done;
          m1_awready = s_awready  & ~aw_done;
          s_wdata    = m1_wdata;
          s_wstrb    = m1_wstrb;
          s_wvalid   = m1_wvalid  & ~w_done;
          m1_wready  = s_wready   & ~w_done;
        end
        WRESP: begin
          m1_bresp  = s_bresp;
          m1_bvalid = s_bvalid;
          s_bready  = m1_bready;
        end
        default: ;
      endcase
    end
  end

endmodule
